// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package riscv_fetch_pkg;

   localparam int DEF_PC_W   = 9;
   localparam int DEF_INST_W = 32;

   localparam logic [DEF_INST_W-1:0] NOP_INST = 32'h0000_0013;

   // One fetched instruction with its PC; used by the skid buffer and IF/ID.
   typedef struct packed {
      logic [DEF_PC_W-1:0]   pc;
      logic [DEF_INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: parks the memory response that arrives while the
// pipeline is stalled so it can be replayed on release.
module fetch_skid_buf
   import riscv_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         capture,
   input  logic         clear,
   input  fetch_entry_t capture_entry,
   output logic         valid,
   output fetch_entry_t entry
);

   // NOTE: only the valid flag needs reset; the payload is ignored while
   // valid is low, so it is loaded without a reset term.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         entry <= capture_entry;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, synchronous-read IMEM interface, skid
// buffer and IF/ID register. Optional stall counter: define FETCH_STALL_CNT_EN.
module fetch_stage
   import riscv_fetch_pkg::*;
#(
   parameter int                  PC_W     = DEF_PC_W,
   parameter int                  INST_W   = DEF_INST_W,
   parameter logic [PC_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [PC_W-1:0]   redirect_pc_i,
   output logic [PC_W-1:0]   imem_addr_o,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [PC_W-1:0]   ifid_pc_o,
   output logic [INST_W-1:0] ifid_inst_o,
   output logic              ifid_valid_o,
   output logic [6:0]        ifid_opcode_o,
   output logic [2:0]        ifid_funct3_o,
   output logic [15:0]       stall_cnt_o
);

   logic [PC_W-1:0] pc_q;
   logic            resp_valid_q;
   logic [PC_W-1:0] resp_pc_q;
   fetch_entry_t    ifid_q;
   logic            ifid_valid_q;

   logic            skid_valid;
   fetch_entry_t    skid_entry;
   fetch_entry_t    resp_entry;
   logic            skid_capture;
   logic            skid_clear;

   // Target word alignment makes the low redirect bits irrelevant.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   assign resp_entry   = '{pc: resp_pc_q, inst: imem_rdata_i};
   assign skid_capture = stall_i && !redirect_i && resp_valid_q && !skid_valid;
   assign skid_clear   = redirect_i || !stall_i;

   fetch_skid_buf u_skid (
      .clk           (clk),
      .reset         (reset),
      .capture       (skid_capture),
      .clear         (skid_clear),
      .capture_entry (resp_entry),
      .valid         (skid_valid),
      .entry         (skid_entry)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q         <= RESET_PC;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= '0;
         ifid_q       <= '{pc: '0, inst: NOP_INST};
         ifid_valid_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q         <= {redirect_pc_i[PC_W-1:2], 2'b00};
         resp_valid_q <= 1'b0;
         ifid_q.inst  <= NOP_INST;
         ifid_valid_q <= 1'b0;
      end else if (stall_i) begin
         // The held address is re-read; that duplicate response is dropped.
         resp_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_q + PC_W'(4);
         resp_valid_q <= 1'b1;
         resp_pc_q    <= pc_q;
         if (skid_valid) begin
            ifid_q       <= skid_entry;
            ifid_valid_q <= 1'b1;
         end else if (resp_valid_q) begin
            ifid_q       <= resp_entry;
            ifid_valid_q <= 1'b1;
         end else begin
            ifid_q.inst  <= NOP_INST;
            ifid_valid_q <= 1'b0;
         end
      end
   end

   assign imem_addr_o   = pc_q;
   assign ifid_pc_o     = ifid_q.pc;
   assign ifid_inst_o   = ifid_q.inst;
   assign ifid_valid_o  = ifid_valid_q;
   assign ifid_opcode_o = ifid_q.inst[6:0];
   assign ifid_funct3_o = ifid_q.inst[14:12];

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (stall_i && !redirect_i && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic against an instruction-stream reference model.
module tb_fetch_stage;
   import riscv_fetch_pkg::*;

   localparam int PC_W   = 9;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall_i;
   logic              redirect_i;
   logic [PC_W-1:0]   redirect_pc_i;
   logic [PC_W-1:0]   imem_addr_o;
   logic [INST_W-1:0] imem_rdata_i;
   logic [PC_W-1:0]   ifid_pc_o;
   logic [INST_W-1:0] ifid_inst_o;
   logic              ifid_valid_o;
   logic [6:0]        ifid_opcode_o;
   logic [2:0]        ifid_funct3_o;
   logic [15:0]       stall_cnt_o;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .ifid_pc_o     (ifid_pc_o),
      .ifid_inst_o   (ifid_inst_o),
      .ifid_valid_o  (ifid_valid_o),
      .ifid_opcode_o (ifid_opcode_o),
      .ifid_funct3_o (ifid_funct3_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory, 128 words.
   logic [INST_W-1:0] mem [128];
   always @(posedge clk) imem_rdata_i <= mem[imem_addr_o[8:2]];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the stage delivers instructions in program order,
   // starting at next_pc after a given number of bubble cycles; a stall
   // freezes everything visible.
   logic [PC_W-1:0]   m_pc;
   logic [INST_W-1:0] m_inst;
   logic              m_valid;
   logic [PC_W-1:0]   m_next_pc;
   int                m_bubbles;
   int                m_cnt;

   task automatic model_edge();
      if (!reset) begin
         m_pc = '0; m_inst = NOP_INST; m_valid = 1'b0;
         m_next_pc = '0; m_bubbles = 1; m_cnt = 0;
      end else if (redirect_i) begin
         m_valid = 1'b0; m_inst = NOP_INST;
         m_next_pc = {redirect_pc_i[8:2], 2'b00};
         m_bubbles = 1;
      end else if (stall_i) begin
         if (m_cnt < 65535) m_cnt++;
      end else if (m_bubbles > 0) begin
         m_valid = 1'b0; m_inst = NOP_INST;
         m_bubbles--;
      end else begin
         m_valid = 1'b1;
         m_pc = m_next_pc;
         m_inst = mem[m_next_pc[8:2]];
         m_next_pc = (m_next_pc + 9'd4) % 512;
      end
   endtask

   task automatic compare_all();
      int exp_addr;
      exp_addr = (m_bubbles == 0) ? (int'(m_next_pc) + 4) % 512 : int'(m_next_pc);
      check("valid",  32'(ifid_valid_o),  32'(m_valid));
      check("pc",     32'(ifid_pc_o),     32'(m_pc));
      check("inst",   ifid_inst_o,        m_inst);
      check("opcode", 32'(ifid_opcode_o), 32'(m_inst[6:0]));
      check("funct3", 32'(ifid_funct3_o), 32'(m_inst[14:12]));
      check("addr",   32'(imem_addr_o),   32'(exp_addr));
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
`else
      check("stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'(i);
      reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      repeat (3) tick();
      check("rst_addr", 32'(imem_addr_o), 32'h0);
      check("rst_opcode", 32'(ifid_opcode_o), 32'h13);

      // Sequential fetch over word[i] = i.
      reset = 1'b1;
      tick();
      check("first_bubble", 32'(ifid_valid_o), 32'd0);
      tick();
      check("first_pc", 32'(ifid_pc_o), 32'h0);
      check("first_valid", 32'(ifid_valid_o), 32'd1);
      tick();
      check("seq_inst1", ifid_inst_o, 32'd1);
      tick();
      check("seq_pc8", 32'(ifid_pc_o), 32'h8);

      // Single-cycle stall while IF/ID holds pc 8: 8,8,12,16.
      stall_i = 1'b1;
      tick();
      check("stall1_hold", 32'(ifid_pc_o), 32'h8);
      stall_i = 1'b0;
      tick();
      check("stall1_rel", 32'(ifid_pc_o), 32'hC);
      tick();
      check("stall1_next", 32'(ifid_pc_o), 32'h10);

      // 4-cycle stall from a fresh counter.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (4) tick();
      stall_i = 1'b1;
      repeat (4) tick();
      check("stall4_hold", 32'(ifid_pc_o), 32'h8);
`ifdef FETCH_STALL_CNT_EN
      check("stall4_cnt", 32'(stall_cnt_o), 32'd4);
`endif
      stall_i = 1'b0;
      tick();
      check("stall4_rel", 32'(ifid_pc_o), 32'hC);
      tick();

      // Redirect to 0x043, forced to 0x040.
      redirect_i = 1'b1; redirect_pc_i = 9'h043;
      tick();
      redirect_i = 1'b0;
      check("redir_addr", 32'(imem_addr_o), 32'h040);
      check("redir_b1", 32'(ifid_valid_o), 32'd0);
      check("redir_op1", 32'(ifid_opcode_o), 32'h13);
      tick();
      check("redir_b2", 32'(ifid_valid_o), 32'd0);
      tick();
      check("redir_pc", 32'(ifid_pc_o), 32'h040);
      check("redir_inst", ifid_inst_o, 32'h10);

      // Stall first (fills skid), then redirect+stall to 0x1F8; wrap to 0.
      stall_i = 1'b1;
      tick();
      redirect_i = 1'b1; redirect_pc_i = 9'h1F8;
      tick();
      redirect_i = 1'b0; stall_i = 1'b0;
      tick();
      check("rs_bubble", 32'(ifid_valid_o), 32'd0);
      tick();
      check("rs_pc", 32'(ifid_pc_o), 32'h1F8);
      check("wrap_addr", 32'(imem_addr_o), 32'h000);
      tick();
      check("wrap_1fc", 32'(ifid_pc_o), 32'h1FC);
      tick();
      check("wrap_000", 32'(ifid_pc_o), 32'h000);

      // Reset asserted during an active stall.
      stall_i = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_stall_valid", 32'(ifid_valid_o), 32'd0);
      check("rst_stall_pc", 32'(ifid_pc_o), 32'h0);
      check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      stall_i = 1'b0;

      // Randomized traffic over random memory contents.
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      tick();
      reset = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         int r;
         r = int'($urandom_range(0, 99));
         reset         = (r >= 98) ? 1'b0 : 1'b1;
         redirect_i    = (r < 8) ? 1'b1 : 1'b0;
         stall_i       = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         redirect_pc_i = 9'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
